// File: rtl/aes_axil_pkg.sv
// Shared constants and types for the AES AXI4-Lite register file.
//   Word offsets, CTRL/STATUS bit positions, AXI response codes,
//   the captured write request payload and a byte-strobe merge helper.
package aes_axil_pkg;

  localparam int unsigned AXI_DW = 32;
  localparam int unsigned AXI_AW = 6;
  localparam int unsigned STRB_W = AXI_DW / 8;
  localparam int unsigned WORD_W = AXI_AW - 2;

  // Word offsets (byte address >> 2)
  localparam logic [WORD_W-1:0] CTRL_WORD   = 4'd0;
  localparam logic [WORD_W-1:0] STATUS_WORD = 4'd1;
  localparam logic [WORD_W-1:0] KEY0_WORD   = 4'd4;
  localparam logic [WORD_W-1:0] DIN0_WORD   = 4'd8;
  localparam logic [WORD_W-1:0] DOUT0_WORD  = 4'd12;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned STAT_BUSY_BIT   = 0;
  localparam int unsigned STAT_DONE_BIT   = 1;
  localparam int unsigned STAT_ERR_BIT    = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [AXI_DW-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

  // Replace only the bytes of old_v selected by strb
  function automatic logic [AXI_DW-1:0] apply_strb(input logic [AXI_DW-1:0] old_v,
                                                   input logic [AXI_DW-1:0] new_v,
                                                   input logic [STRB_W-1:0] strb);
    logic [AXI_DW-1:0] res;
    res = old_v;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_axil_wr_chan.sv
// AXI4-Lite write channel: independent one-deep AW and W holding registers
// and the B response.
//   awaddr_i/awvalid_i/awready_o : write address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o : write data channel
//   bresp_o/bvalid_o/bready_i : write response channel
//   slverr_i   : response decode for the request presented on req_c_o
//   commit_c_o : both halves held; the register bank applies req_c_o this cycle
module aes_axil_wr_chan
  import aes_axil_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [AXI_AW-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [AXI_DW-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  input  logic              slverr_i,
  output logic              commit_c_o,
  output wr_req_t           req_c_o
);

  logic    aw_held_q, aw_held_d;
  logic    w_held_q, w_held_d;
  wr_req_t req_q, req_d;
  logic    bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;
  logic    awready_q, awready_d;
  logic    wready_q, wready_d;
  logic    unused_addr_lsb;

  assign unused_addr_lsb = ^awaddr_i[1:0];

  // Capture, commit and response sequencing
  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    req_d     = req_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (awvalid_i && awready_q) begin
      aw_held_d  = 1'b1;
      req_d.word = awaddr_i[AXI_AW-1:2];
    end
    if (wvalid_i && wready_q) begin
      w_held_d   = 1'b1;
      req_d.data = wdata_i;
      req_d.strb = wstrb_i;
    end
    if (aw_held_q && w_held_q) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = slverr_i ? RESP_SLVERR : RESP_OKAY;
    end else if (bvalid_q && bready_i) begin
      bvalid_d = 1'b0;
    end
    // Readies stay low from capture until the B handshake: one write in flight
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      req_q     <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      req_q     <= req_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
    end
  end

  assign awready_o  = awready_q;
  assign wready_o   = wready_q;
  assign bvalid_o   = bvalid_q;
  assign bresp_o    = bresp_q;
  assign commit_c_o = aw_held_q && w_held_q;
  assign req_c_o    = req_q;

endmodule

// File: rtl/aes_axil_regs.sv
// AXI4-Lite register file in front of the AES core.
//   ACLK/ARESETN : clock, async active-low reset
//   S_AXI_*      : AXI4-Lite slave (AWPROT/ARPROT ignored)
//   aes_key/aes_din : KEY3..0 / DIN3..0, word 3 is the MSW
//   aes_start    : one-cycle launch pulse
//   aes_dout/aes_done : core result and completion pulse
//   irq          : STATUS.done & CTRL.irq_en
module aes_axil_regs
  import aes_axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [127:0]                    aes_key,
  output logic [127:0]                    aes_din,
  output logic                            aes_start,
  input  logic [127:0]                    aes_dout,
  input  logic                            aes_done,
  output logic                            irq
);

  logic irq_en_q, irq_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic start_q, start_d, irq_q, irq_d;
  logic [3:0][AXI_DW-1:0] key_q, key_d, din_q, din_d, dout_q, dout_d;
  logic              rvalid_q, rvalid_d, arready_q, arready_d;
  logic [AXI_DW-1:0] rdata_q, rdata_d, rd_mux_c;
  logic [WORD_W-1:0] rd_word_c, wr_word_c;
  logic              wr_commit_c, wr_slverr_c;
  wr_req_t           wr_req_c;
  logic              unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0]};

  aes_axil_wr_chan u_wr_chan (
    .clk_i      (ACLK),
    .rst_ni     (ARESETN),
    .awaddr_i   (S_AXI_AWADDR),
    .awvalid_i  (S_AXI_AWVALID),
    .awready_o  (S_AXI_AWREADY),
    .wdata_i    (S_AXI_WDATA),
    .wstrb_i    (S_AXI_WSTRB),
    .wvalid_i   (S_AXI_WVALID),
    .wready_o   (S_AXI_WREADY),
    .bresp_o    (S_AXI_BRESP),
    .bvalid_o   (S_AXI_BVALID),
    .bready_i   (S_AXI_BREADY),
    .slverr_i   (wr_slverr_c),
    .commit_c_o (wr_commit_c),
    .req_c_o    (wr_req_c)
  );

  // Register bank: write commit, then core completion (so done-set beats W1C)
  always_comb begin
    irq_en_d    = irq_en_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    key_d       = key_q;
    din_d       = din_q;
    dout_d      = dout_q;
    start_d     = 1'b0;
    wr_slverr_c = 1'b0;
    wr_word_c   = wr_req_c.word;
    if (wr_commit_c) begin
      if (wr_word_c == CTRL_WORD) begin
        if (wr_req_c.strb[0]) begin
          irq_en_d = wr_req_c.data[CTRL_IRQ_EN_BIT];
          if (wr_req_c.data[CTRL_START_BIT]) begin
            if (busy_q) begin
              err_d       = 1'b1;
              wr_slverr_c = 1'b1;
            end else begin
              start_d = 1'b1;
              busy_d  = 1'b1;
              done_d  = 1'b0;
            end
          end
        end
      end else if (wr_word_c == STATUS_WORD) begin
        if (wr_req_c.strb[0] && wr_req_c.data[STAT_DONE_BIT]) done_d = 1'b0;
        if (wr_req_c.strb[0] && wr_req_c.data[STAT_ERR_BIT])  err_d  = 1'b0;
      end else if (wr_word_c[3:2] == KEY0_WORD[3:2]) begin
        key_d[wr_word_c[1:0]] = apply_strb(key_q[wr_word_c[1:0]], wr_req_c.data, wr_req_c.strb);
      end else if (wr_word_c[3:2] == DIN0_WORD[3:2]) begin
        din_d[wr_word_c[1:0]] = apply_strb(din_q[wr_word_c[1:0]], wr_req_c.data, wr_req_c.strb);
      end else begin
        wr_slverr_c = 1'b1;  // DOUT and reserved words
      end
    end
    if (aes_done && busy_q) begin
      dout_d = aes_dout;
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    irq_d = done_d && irq_en_d;
  end

  // Read path: mux samples pre-commit register state
  always_comb begin
    rd_word_c = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    rd_mux_c  = '0;
    if (rd_word_c == CTRL_WORD) begin
      rd_mux_c[CTRL_IRQ_EN_BIT] = irq_en_q;
    end else if (rd_word_c == STATUS_WORD) begin
      rd_mux_c[STAT_BUSY_BIT] = busy_q;
      rd_mux_c[STAT_DONE_BIT] = done_q;
      rd_mux_c[STAT_ERR_BIT]  = err_q;
    end else if (rd_word_c[3:2] == KEY0_WORD[3:2]) begin
      rd_mux_c = key_q[rd_word_c[1:0]];
    end else if (rd_word_c[3:2] == DIN0_WORD[3:2]) begin
      rd_mux_c = din_q[rd_word_c[1:0]];
    end else if (rd_word_c[3:2] == DOUT0_WORD[3:2]) begin
      rd_mux_c = dout_q[rd_word_c[1:0]];
    end
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (S_AXI_ARVALID && arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux_c;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
    arready_d = !rvalid_d;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      irq_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      irq_q     <= 1'b0;
      key_q     <= '0;
      din_q     <= '0;
      dout_q    <= '0;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      irq_en_q  <= irq_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      start_q   <= start_d;
      irq_q     <= irq_d;
      key_q     <= key_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      rvalid_q  <= rvalid_d;
      arready_q <= arready_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign aes_key       = key_q;
  assign aes_din       = din_q;
  assign aes_start     = start_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_aes_axil_regs.sv
// Self-checking bench for aes_axil_regs: table of write/read-back vectors
// plus directed sequences for launch, irq, busy restart, DOUT protection,
// skewed AW/W with B back-pressure, and mid-transaction reset.
module tb_aes_axil_regs;

  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLV  = 2'b10;

  logic         clk = 1'b0;
  logic         ARESETN;
  logic [5:0]   S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]   S_AXI_AWPROT, S_AXI_ARPROT;
  logic         S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0]  S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
  logic         S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic         S_AXI_RVALID, S_AXI_RREADY;
  logic [127:0] aes_key, aes_din, aes_dout;
  logic         aes_start, aes_done, irq;

  always #5 clk = ~clk;

  aes_axil_regs dut (
    .ACLK(clk), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .aes_key(aes_key), .aes_din(aes_din), .aes_start(aes_start),
    .aes_dout(aes_dout), .aes_done(aes_done), .irq(irq)
  );

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int brise_cnt = 0;
  logic bvalid_prev = 1'b0;

  // Count start-pulse cycles and BVALID rising edges
  always @(negedge clk) begin
    if (aes_start) start_cnt <= start_cnt + 1;
    if (S_AXI_BVALID && !bvalid_prev) brise_cnt <= brise_cnt + 1;
    bvalid_prev <= S_AXI_BVALID;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: handshake timeout, got none expected one", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_p, w_p, aw_f, w_f, got;
    int t;
    resp = 2'bxx;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    aw_p = 1'b1; w_p = 1'b1; t = 0;
    while ((aw_p || w_p) && t < 50) begin
      aw_f = aw_p && S_AXI_AWREADY;
      w_f  = w_p && S_AXI_WREADY;
      @(posedge clk); #1;
      if (aw_f) begin aw_p = 1'b0; S_AXI_AWVALID = 1'b0; end
      if (w_f)  begin w_p = 1'b0;  S_AXI_WVALID = 1'b0;  end
      t++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    if (aw_p || w_p) timeout_fail("write_addr_data");
    S_AXI_BREADY = 1'b1; got = 1'b0; t = 0;
    while (!got && t < 50) begin
      if (S_AXI_BVALID) begin got = 1'b1; resp = S_AXI_BRESP; end
      @(posedge clk); #1;
      t++;
    end
    S_AXI_BREADY = 1'b0;
    if (!got) timeout_fail("write_resp");
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit f, got;
    int t;
    d = 'x; resp = 2'bxx;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; t = 0; f = 1'b0;
    while (!f && t < 50) begin
      f = S_AXI_ARREADY;
      @(posedge clk); #1;
      t++;
    end
    S_AXI_ARVALID = 1'b0;
    if (!f) timeout_fail("read_addr");
    S_AXI_RREADY = 1'b1; got = 1'b0; t = 0;
    while (!got && t < 50) begin
      if (S_AXI_RVALID) begin got = 1'b1; d = S_AXI_RDATA; resp = S_AXI_RRESP; end
      @(posedge clk); #1;
      t++;
    end
    S_AXI_RREADY = 1'b0;
    if (!got) timeout_fail("read_data");
  endtask

  task automatic read_check(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check(name, 128'(d), 128'(exp));
  endtask

  task automatic pulse_done(input logic [127:0] v);
    aes_dout = v; aes_done = 1'b1;
    @(posedge clk); #1;
    aes_done = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [127:0] da, db, dc;
    logic [31:0]  rd;
    logic [1:0]   rr, br;
    int s0, b0, t;
    bit f;

    vecs[0]  = '{6'h10, 32'h00000001, 4'hF, OKAY, 32'h00000001};
    vecs[1]  = '{6'h14, 32'h00000002, 4'hF, OKAY, 32'h00000002};
    vecs[2]  = '{6'h18, 32'h00000003, 4'hF, OKAY, 32'h00000003};
    vecs[3]  = '{6'h1C, 32'h00000004, 4'hF, OKAY, 32'h00000004};
    vecs[4]  = '{6'h20, 32'h11223344, 4'hF, OKAY, 32'h11223344};
    vecs[5]  = '{6'h20, 32'hAABBCCDD, 4'h5, OKAY, 32'h11BB33DD};
    vecs[6]  = '{6'h08, 32'hFFFFFFFF, 4'hF, SLV,  32'h00000000};
    vecs[7]  = '{6'h0C, 32'hFFFFFFFF, 4'hF, SLV,  32'h00000000};
    vecs[8]  = '{6'h04, 32'h00000000, 4'hF, OKAY, 32'h00000000};
    vecs[9]  = '{6'h00, 32'h00000002, 4'hF, OKAY, 32'h00000002};
    vecs[10] = '{6'h00, 32'h00000000, 4'hF, OKAY, 32'h00000000};
    da = 128'hA5000003_A5000002_A5000001_A5000000;
    db = 128'hB0000003_B0000002_B0000001_B0000000;
    dc = 128'hC0000003_C0000002_C0000001_C0000000;

    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    aes_dout = '0; aes_done = 1'b0;
    ARESETN = 1'b1;
    #2 ARESETN = 1'b0;
    tick(3);
    check("reset_ctl_outputs",
          128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, aes_start, irq}),
          128'(0));
    check("reset_resp_rdata", 128'({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}), 128'(0));
    check("reset_key_din", aes_key | aes_din, 128'(0));
    ARESETN = 1'b1;
    tick(2);

    // Write then read back each vector
    for (int i = 0; i < 11; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, br);
      check($sformatf("vec%0d_bresp", i), 128'(br), 128'(vecs[i].bresp));
      axi_read(vecs[i].addr, rd, rr);
      check($sformatf("vec%0d_rdata", i), 128'(rd), 128'(vecs[i].rdata));
      check($sformatf("vec%0d_rresp", i), 128'(rr), 128'(OKAY));
    end
    check("aes_key", aes_key, 128'h00000004_00000003_00000002_00000001);
    check("aes_din", aes_din, 128'h00000000_00000000_00000000_11BB33DD);

    // Launch and completion
    s0 = start_cnt;
    axi_write(6'h00, 32'h1, 4'hF, br);
    check("launch_bresp", 128'(br), 128'(OKAY));
    tick(1);
    check("launch_start_cycles", 128'(start_cnt - s0), 128'(1));
    read_check("launch_status", 6'h04, 32'h1);
    read_check("launch_ctrl_reads_no_start", 6'h00, 32'h0);
    pulse_done(da);
    for (int i = 0; i < 4; i++)
      read_check($sformatf("dout%0d_a", i), 6'(6'h30 + 4*i), da[32*i +: 32]);
    read_check("done_status", 6'h04, 32'h2);
    check("irq_disabled", 128'(irq), 128'(0));

    // Launch with irq enabled, then W1C done
    axi_write(6'h00, 32'h3, 4'hF, br);
    read_check("irq_launch_status", 6'h04, 32'h1);
    check("irq_low_while_busy", 128'(irq), 128'(0));
    pulse_done(db);
    check("irq_high_on_done", 128'(irq), 128'(1));
    read_check("irq_done_status", 6'h04, 32'h2);
    axi_write(6'h04, 32'h2, 4'hF, br);
    check("w1c_bresp", 128'(br), 128'(OKAY));
    check("irq_low_after_w1c", 128'(irq), 128'(0));
    read_check("w1c_status", 6'h04, 32'h0);

    // Start while busy is rejected
    s0 = start_cnt;
    axi_write(6'h00, 32'h3, 4'hF, br);
    axi_write(6'h00, 32'h1, 4'hF, br);
    check("busy_start_bresp", 128'(br), 128'(SLV));
    read_check("busy_start_status", 6'h04, 32'h5);
    tick(2);
    check("busy_start_single_pulse", 128'(start_cnt - s0), 128'(1));
    pulse_done(dc);
    read_check("busy_done_status", 6'h04, 32'h6);
    axi_write(6'h04, 32'h6, 4'hE, br);
    read_check("w1c_strobe_masked", 6'h04, 32'h6);
    axi_write(6'h04, 32'h6, 4'hF, br);
    read_check("w1c_all_clear", 6'h04, 32'h0);
    pulse_done(da);
    read_check("idle_done_ignored_dout", 6'h30, dc[31:0]);
    read_check("idle_done_ignored_status", 6'h04, 32'h0);

    // DOUT is read-only
    axi_write(6'h30, 32'hDEADBEEF, 4'b0011, br);
    check("dout_write_bresp", 128'(br), 128'(SLV));
    read_check("dout_write_no_effect", 6'h30, dc[31:0]);

    // W three cycles ahead of AW, BREADY held low five cycles
    b0 = brise_cnt;
    S_AXI_BREADY = 1'b0;
    S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge clk); #1;
      if (f) S_AXI_WVALID = 1'b0;
    end
    check("early_w_held_wready", 128'({S_AXI_WREADY, S_AXI_BVALID, S_AXI_WVALID}), 128'(0));
    S_AXI_AWADDR = 6'h18; S_AXI_AWVALID = 1'b1; f = 1'b0; t = 0;
    while (!f && t < 50) begin
      f = S_AXI_AWREADY;
      @(posedge clk); #1;
      t++;
    end
    S_AXI_AWVALID = 1'b0;
    if (!f) timeout_fail("skew_aw");
    t = 0;
    while (!S_AXI_BVALID && t < 50) begin tick(1); t++; end
    if (!S_AXI_BVALID) timeout_fail("skew_bvalid");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_awr_wr_bv", i),
            128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}), 128'(3'b001));
      tick(1);
    end
    check("skew_bresp", 128'(S_AXI_BRESP), 128'(OKAY));
    S_AXI_BREADY = 1'b1;
    tick(1);
    S_AXI_BREADY = 1'b0;
    check("skew_after_b", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}), 128'(3'b110));
    check("skew_single_commit", 128'(brise_cnt - b0), 128'(1));
    read_check("skew_key2", 6'h18, 32'hCAFEF00D);
    check("skew_aes_key", aes_key, 128'h00000004_CAFEF00D_00000002_00000001);

    // Reset with a busy core and a half-captured write
    axi_write(6'h00, 32'h3, 4'hF, br);
    S_AXI_AWADDR = 6'h10; S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    tick(1);
    #2 ARESETN = 1'b0;
    #1;
    check("async_rst_ctl_outputs",
          128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, aes_start, irq}),
          128'(0));
    check("async_rst_key_din", aes_key | aes_din, 128'(0));
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    tick(1);
    ARESETN = 1'b1;
    tick(2);
    pulse_done(da);
    read_check("post_rst_status", 6'h04, 32'h0);
    read_check("post_rst_dout0", 6'h30, 32'h0);
    read_check("post_rst_key0", 6'h10, 32'h0);
    tick(2);
    check("post_rst_no_bvalid", 128'(S_AXI_BVALID), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_axil_regs.md
# aes_axil_regs

AXI4-Lite slave register file fronting the AES core inside the AES_improved IP. It terminates the transactions issued by the block-design master agent. It holds the 128-bit key and data-in words and launches the core with a start pulse. It captures the 128-bit result and reports busy/done status through readable registers plus a level interrupt.

## Interface
- C_S_AXI_DATA_WIDTH, 32, register width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; decodes 16 words.
- ACLK  in  1  single clock for all logic.
- ARESETN  in  1  reset, asynchronous, active-low.
- S_AXI_AWADDR / AWPROT / AWVALID / AWREADY  in/in/in/out  6/3/1/1  write address channel; AWPROT is ignored.
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR / ARPROT / ARVALID / ARREADY  in/in/in/out  6/3/1/1  read address channel; ARPROT is ignored.
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  32/2/1/1  read data channel.
- aes_key  out  128  KEY3..KEY0 concatenated; KEY3 is the MSW.
- aes_din  out  128  DIN3..DIN0 concatenated; DIN3 is the MSW.
- aes_start  out  1  one-cycle launch pulse to the core.
- aes_dout  in  128  core result, valid when aes_done is high.
- aes_done  in  1  one-cycle completion pulse from the core.
- irq  out  1  level interrupt, equal to STATUS.done & CTRL.irq_en.

## Operation
- Register map:
  - 0x00 CTRL: bit0 start, write-1 to launch; always reads 0. Bit1 irq_en, R/W.
  - 0x04 STATUS, RO except W1C bits: bit0 busy; bit1 done (W1C); bit2 err (W1C).
  - 0x08 and 0x0C: reserved.
  - 0x10–0x1C KEY0–3, R/W.
  - 0x20–0x2C DIN0–3, R/W.
  - 0x30–0x3C DOUT0–3, RO.
- Writes honour WSTRB byte-wise on R/W registers. W1C bits clear only where the strobe covers the bit.
- BRESP rules:
  - OKAY for writes to R/W and W1C registers.
  - SLVERR for writes to DOUT, reserved or unmapped words; these have no side effects.
- RRESP is always OKAY. Reserved words read 0.
- CTRL.start with busy=0: aes_start pulses; busy sets and done clears on the same cycle.
- CTRL.start with busy=1: the start is dropped, err sets, and BRESP is SLVERR.
- KEY/DIN writes while busy are accepted; they affect only the next launch.
- aes_done: DOUT0–3 ← aes_dout, busy clears, done sets.
- Same-cycle aes_done and done W1C: set wins.
- aes_done while busy=0 is ignored.

## Timing
- Reset values:
  - All registers 0.
  - AWREADY, WREADY, ARREADY, BVALID, RVALID = 0.
  - BRESP/RRESP = 0 and RDATA = 0.
  - aes_start = 0 and irq = 0.
- AW and W are accepted independently into one-deep holding registers.
- AWREADY is high when no address is held and BVALID=0. WREADY follows the same rule for data.
- The register write commits on the cycle after both halves are held. BVALID rises that same cycle. aes_start, when launched, is asserted that same cycle.
- BVALID holds until BREADY. Exactly one write is outstanding at a time.
- ARREADY is high when RVALID=0 and no read is pending. RVALID rises the cycle after the AR handshake and holds with stable RDATA until RREADY.
- Read and write paths are independent.
- A read of STATUS in the same cycle as a write commit returns the pre-commit value.
- ARESETN asserted mid-transaction aborts all channels. Outputs return to reset values asynchronously, and a busy core result is discarded.

## Structure
- Package aes_axil_pkg holds:
  - Word-offset localparams (CTRL, STATUS, KEY0, DIN0, DOUT0).
  - STATUS/CTRL bit-index constants.
  - The AXI response encodings OKAY=2'b00 and SLVERR=2'b10.
- One sub-module, aes_axil_wr_chan, covers AW/W capture and the B response. The read path and register bank stay in the top.

## Test plan
- Write 0x00000001..0x00000004 to 0x10–0x1C, then read them back: each read equals the written value with RRESP=OKAY, and aes_key=128'h00000004_00000003_00000002_00000001.
- Write 0x1 to CTRL: aes_start pulses one cycle and STATUS reads 0x1. Core aes_done with aes_dout=128'hA5…: DOUT words match, STATUS=0x2.
- Repeat the launch with CTRL.irq_en=1: irq rises with done. Write 0x2 to STATUS (W1C): irq falls.
- Write CTRL=0x1 while busy: BRESP=SLVERR, STATUS=0x5, and no second aes_start.
- Write 0xDEADBEEF to 0x30 (DOUT0) with WSTRB=4'b0011: BRESP=SLVERR and DOUT0 is unchanged.
- W asserted 3 cycles before AW, and BREADY held low 5 cycles: the write commits once, and AWREADY/WREADY stay low until the B handshake completes.
